// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC initiator-side sequencer.
//   state_t    - sequencer FSM states
//   ACC_FACTOR - accumulator/result width as a multiple of the operand width
//   STALL_W    - width of the optional per-job stall counter
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    localparam int ACC_FACTOR = 3;
    localparam int STALL_W    = 16;

endpackage

// File: rtl/mac_driver.sv
// mac_driver: sequences one dot-product job into a multiply-accumulate unit.
// Accepts a job (start/len), pulls paired A/B operands from two valid/ready
// streams, drives the MAC En/Clr/Ain/Bin inputs, captures Cout and returns it
// on a valid/ready result port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, len                 job request, product count (clamped to VEC_LEN)
//   a_valid/a_ready/a_data     A operand stream
//   b_valid/b_ready/b_data     B operand stream
//   mac_en, mac_clr            MAC enable / clear
//   mac_a, mac_b               MAC operand inputs
//   mac_cout                   MAC registered accumulator output
//   res_valid/res_ready/res_data  result stream
//   busy                       high whenever the FSM is not IDLE
//   stall_cnt                  FEED cycles without a beat in the current job
//                              (present only with MAC_DRIVER_STALL_CNT_EN)
//
// Build option: define MAC_DRIVER_STALL_CNT_EN to add the stall_cnt output.
module mac_driver
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    localparam int CW = $clog2(VEC_LEN + 1),
    localparam int RW = DATA_WIDTH * ACC_FACTOR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CW-1:0]         len,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [RW-1:0]         mac_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [RW-1:0]         res_data,
    output logic                  busy
`ifdef MAC_DRIVER_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]    stall_cnt
`endif
);

    state_t        state, state_nxt;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] len_clamp;
    logic          in_feed;
    logic          beat;

    assign in_feed   = (state == FEED);
    assign beat      = in_feed & a_valid & b_valid;
    assign cnt_inc   = cnt + CW'(1);
    assign len_clamp = (int'(len) > VEC_LEN) ? CW'(VEC_LEN) : len;

    // Each stream's ready follows the other's valid so A and B only ever
    // transfer as a pair.
    assign a_ready   = in_feed & b_valid;
    assign b_ready   = in_feed & a_valid;

    // En stays up through stalls: the MAC adds a zero product rather than
    // dropping to idle and demanding another priming cycle.
    assign mac_en    = (state == PRIME) | in_feed;
    assign mac_clr   = (state == CLEAR);
    assign mac_a     = beat ? a_data : '0;
    assign mac_b     = beat ? b_data : '0;
    assign res_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len_clamp != '0) ? PRIME : DRAIN;
            PRIME:   state_nxt = FEED;
            FEED:    if (beat && (cnt_inc == len_q)) state_nxt = DRAIN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = CLEAR;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt      <= '0;
            res_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                len_q <= len_clamp;
                cnt   <= '0;
            end else if (beat) begin
                cnt <= cnt_inc;
            end
            // The last product landed in Cout at the edge that entered DRAIN.
            if (state == DRAIN) res_data <= mac_cout;
        end
    end

`ifdef MAC_DRIVER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (in_feed && !beat && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mac_driver.sv
// tb_mac_driver: pairs mac_driver with a behavioural MAC and checks result
// values, handshake timing, MAC control activity and stream behaviour.
// Build option MAC_DRIVER_STALL_CNT_EN adds stall counter checks.
module tb_mac_driver;

    localparam int DW = 8;
    localparam int VL = 8;
    localparam int CW = $clog2(VL + 1);
    localparam int RW = 3 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          mac_en, mac_clr;
    logic [DW-1:0] mac_a, mac_b;
    logic [RW-1:0] mac_cout;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          busy;
`ifdef MAC_DRIVER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    mac_driver #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cout(mac_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
`ifdef MAC_DRIVER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Behavioural MAC: first En cycle after idle/clear only primes.
    logic          primed;
    logic [RW-1:0] acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; primed <= 1'b0;
        end else if (mac_clr) begin
            acc <= '0; primed <= 1'b0;
        end else if (mac_en) begin
            if (primed) acc <= acc + RW'(mac_a) * RW'(mac_b);
            primed <= 1'b1;
        end else begin
            primed <= 1'b0;
        end
    end
    assign mac_cout = acc;

    // Activity monitors (cleared by the tests).
    int en_cnt, clr_cnt, beat_cnt, rdy_cnt;
    always @(posedge clk) begin
        if (mac_en) en_cnt++;
        if (mac_clr) clr_cnt++;
        if (a_valid && a_ready) beat_cnt++;
        if (a_ready || b_ready) rdy_cnt++;
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] opa[16];
    logic [DW-1:0] opb[16];
    logic [RW-1:0] exp_q[$];

    task automatic clr_mon();
        en_cnt = 0; clr_cnt = 0; beat_cnt = 0; rdy_cnt = 0;
    endtask

    // Scoreboard entry: plain dot product of the clamped operand count.
    task automatic push_exp(input int n);
        int eff;
        logic [RW-1:0] s;
        eff = (n > VL) ? VL : n;
        s = '0;
        for (int i = 0; i < eff; i++) s = s + RW'(opa[i]) * RW'(opb[i]);
        exp_q.push_back(s);
    endtask

    // Runs one job. stall: A-valid gap after the first beat. hold_wait: HOLD
    // cycles with res_ready low (start pulsed meanwhile). keep_valid: offer
    // operands beyond the job length. Returns at #1 after the handshake edge,
    // with edges counted from E0.
    task automatic run_job(input int n, input int stall, input int hold_wait,
                           input bit keep_valid, output logic [RW-1:0] got,
                           output int hs_edge, output bit hold_stable,
                           output bit timeout);
        int eff, idx, sl, hc, e;
        bit beat, done;
        logic [RW-1:0] first;
        eff = (n > VL) ? VL : n;
        push_exp(n);
        @(posedge clk); #1;
        start = 1'b1; len = CW'(n); res_ready = (hold_wait == 0);
        @(posedge clk); #1;
        start = 1'b0;
        e = 0; idx = 0; sl = 0; hc = 0; done = 1'b0;
        hold_stable = 1'b1; timeout = 1'b1; got = '0; hs_edge = -1; first = '0;
        repeat (300) begin
            a_valid   = keep_valid || ((idx < eff) && (sl == 0));
            b_valid   = keep_valid || (idx < eff);
            a_data    = (idx < eff) ? opa[idx] : '0;
            b_data    = (idx < eff) ? opb[idx] : '0;
            res_ready = (hc >= hold_wait);
            start     = (hold_wait > 0) && (hc > 0) && (hc < hold_wait);
            @(negedge clk);
            beat = a_valid && a_ready;
            if (res_valid) begin
                if (hc == 0) first = res_data;
                else if (res_data !== first) hold_stable = 1'b0;
                if (res_ready) begin done = 1'b1; got = res_data; end
                else hc++;
            end
            @(posedge clk); e++; #1;
            if (beat) begin
                idx++;
                if (idx == 1) sl = stall;
            end else if (sl > 0) begin
                sl--;
            end
            if (done) begin hs_edge = e; timeout = 1'b0; break; end
        end
        a_valid = 1'b0; b_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
        #2;
        total++;
        if ({busy, mac_en, mac_clr, a_ready, b_ready, res_valid, mac_a, mac_b, res_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b en=%b clr=%b ar=%b br=%b rv=%b a=%0d b=%0d rd=%0d want all 0",
                     busy, mac_en, mac_clr, a_ready, b_ready, res_valid, mac_a, mac_b, res_data);
        end
`ifdef MAC_DRIVER_STALL_CNT_EN
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [RW-1:0] got, exp;
        int he; bit hs, to;
        opa[0] = 1; opa[1] = 2; opa[2] = 3;
        opb[0] = 4; opb[1] = 5; opb[2] = 6;
        clr_mon();
        run_job(3, 0, 0, 1'b0, got, he, hs, to);
        exp = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL basic_timeout: no result in budget"); end
        total++; if (got !== exp) begin bad++; $display("FAIL basic_data: got %0d want %0d", got, exp); end
        total++; if (he !== 6) begin bad++; $display("FAIL basic_edge: got E%0d want E6", he); end
        total++; if (mac_clr !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL basic_clear_cycle: got clr=%b rv=%b want clr=1 rv=0", mac_clr, res_valid);
        end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
        total++; if (clr_cnt !== 1) begin bad++; $display("FAIL basic_clr_cnt: got %0d want 1", clr_cnt); end
        total++; if (en_cnt !== 4) begin bad++; $display("FAIL basic_en_cnt: got %0d want 4", en_cnt); end
        total++; if (beat_cnt !== 3) begin bad++; $display("FAIL basic_beats: got %0d want 3", beat_cnt); end
    endtask

    task automatic test_stall();
        logic [RW-1:0] got, exp;
        int he; bit hs, to;
        opa[0] = 255; opa[1] = 255; opb[0] = 255; opb[1] = 255;
        clr_mon();
        run_job(2, 3, 0, 1'b0, got, he, hs, to);
        exp = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL stall_timeout: no result in budget"); end
        total++; if (got !== exp) begin bad++; $display("FAIL stall_data: got %0d want %0d", got, exp); end
        total++; if (he !== 8) begin bad++; $display("FAIL stall_edge: got E%0d want E8", he); end
        // PRIME + 2 beats + 3 stalls with En held throughout.
        total++; if (en_cnt !== 6) begin bad++; $display("FAIL stall_en_cnt: got %0d want 6", en_cnt); end
`ifdef MAC_DRIVER_STALL_CNT_EN
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_len0();
        logic [RW-1:0] got, exp;
        int he; bit hs, to;
        clr_mon();
        run_job(0, 0, 0, 1'b1, got, he, hs, to);
        exp = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL len0_timeout: no result in budget"); end
        total++; if (got !== exp) begin bad++; $display("FAIL len0_data: got %0d want %0d", got, exp); end
        total++; if (he !== 2) begin bad++; $display("FAIL len0_edge: got E%0d want E2", he); end
        @(posedge clk); #1;
        total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL len0_ready: got %0d ready cycles want 0", rdy_cnt); end
        total++; if (en_cnt !== 0) begin bad++; $display("FAIL len0_en: got %0d en cycles want 0", en_cnt); end
    endtask

    task automatic test_hold();
        logic [RW-1:0] got, exp;
        int he; bit hs, to;
        opa[0] = 3; opa[1] = 4; opb[0] = 5; opb[1] = 6;
        clr_mon();
        run_job(2, 0, 10, 1'b1, got, he, hs, to);
        exp = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL hold_timeout: no result in budget"); end
        total++; if (got !== exp) begin bad++; $display("FAIL hold_data: got %0d want %0d", got, exp); end
        total++; if (!hs) begin bad++; $display("FAIL hold_stable: got unstable res_data want stable"); end
        total++; if (he !== 15) begin bad++; $display("FAIL hold_edge: got E%0d want E15", he); end
        @(posedge clk); #1;
        total++; if (clr_cnt !== 1) begin bad++; $display("FAIL hold_clr_cnt: got %0d want 1", clr_cnt); end
        total++; if (beat_cnt !== 2) begin bad++; $display("FAIL hold_beats: got %0d want 2", beat_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] got, exp;
        int he, b0; bit hs, to;
        opa[0] = 10; opa[1] = 11; opa[2] = 12;
        opb[0] = 10; opb[1] = 11; opb[2] = 12;
        @(posedge clk); #1; start = 1'b1; len = CW'(3);
        @(posedge clk); #1; start = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = opa[0]; b_data = opb[0];
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        b0 = beat_cnt;
        #1;
        total++;
        if ({busy, mac_en, mac_clr, a_ready, b_ready, res_valid, mac_a, mac_b, res_data} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got busy=%b en=%b clr=%b ar=%b br=%b rv=%b a=%0d b=%0d rd=%0d want all 0",
                     busy, mac_en, mac_clr, a_ready, b_ready, res_valid, mac_a, mac_b, res_data);
        end
        @(posedge clk); @(posedge clk); #1;
        total++; if (beat_cnt !== b0) begin bad++; $display("FAIL midrst_beats: got %0d beats in reset want 0", beat_cnt - b0); end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        opa[0] = 7; opb[0] = 9;
        run_job(1, 0, 0, 1'b0, got, he, hs, to);
        exp = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL midrst_timeout: no result in budget"); end
        total++; if (got !== exp) begin bad++; $display("FAIL midrst_data: got %0d want %0d", got, exp); end
        total++; if (he !== 4) begin bad++; $display("FAIL midrst_edge: got E%0d want E4", he); end
        @(posedge clk); #1;
    endtask

    // len is CW bits wide, so 15 is the largest over-range request encodable.
    task automatic test_clamp();
        logic [RW-1:0] got, exp;
        int he; bit hs, to;
        for (int i = 0; i < 16; i++) begin opa[i] = 1; opb[i] = 1; end
        clr_mon();
        run_job(15, 0, 0, 1'b1, got, he, hs, to);
        exp = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL clamp_timeout: no result in budget"); end
        total++; if (got !== exp) begin bad++; $display("FAIL clamp_data: got %0d want %0d", got, exp); end
        total++; if (he !== 11) begin bad++; $display("FAIL clamp_edge: got E%0d want E11", he); end
        total++; if (beat_cnt !== 8) begin bad++; $display("FAIL clamp_beats: got %0d want 8", beat_cnt); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len0();
        test_hold();
        test_reset_mid();
        test_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
